run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_ctrl_pkg.sv | 12 +
 rtl/sat_counter.sv | 19 +
 rtl/run_controller.sv | 102 ++++++++++
 tb/tb_run_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: state encoding and status codes shared by the run controller.
package run_ctrl_pkg;
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_RESET_HOLD = 3'd1;
  localparam logic [2:0] S_RUN        = 3'd2;
  localparam logic [2:0] S_DRAIN      = 3'd3;
  localparam logic [2:0] S_DUMP       = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;
  localparam logic [1:0] ST_NONE      = 2'b00;
  localparam logic [1:0] ST_COMPLETE  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] q_o,
  output logic [CNT_W-1:0] nxt_o
);
  logic [CNT_W-1:0] count_q;
  assign nxt_o = (&count_q) ? count_q : count_q + CNT_W'(1);
  assign q_o   = count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else if (clr_i) count_q <= '0;
    else if (en_i) count_q <= nxt_o;
endmodule

// File: rtl/run_controller.sv
// run_controller: sequences core reset, run, drain and state dump for one run,
// stopping on core completion or on a cycle limit.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NCORE        = 1,
  parameter int CNT_W        = 32,
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int DONE_MODE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] run_limit,
  input  logic [NCORE-1:0] core_done,
  output logic             core_reset,
  output logic             dump_req,
  output logic             finish,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       status
);
  localparam logic [7:0] RST_LOAD   = 8'(RST_CYCLES - 1);
  localparam logic [7:0] DRAIN_LOAD = 8'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
  logic [2:0]       state_q, state_d;
  logic [7:0]       tmr_q, tmr_d;
  logic [CNT_W-1:0] limit_q, limit_d, cnt_nxt;
  logic [NCORE-1:0] seen_q, seen_d, seen_all;
  logic [1:0]       status_q, status_d;
  logic             core_reset_q, dump_req_q, finish_q, go, complete, timeout;
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr_i(go),
    .en_i (state_q == S_RUN),
    .q_o  (cycle_count),
    .nxt_o(cnt_nxt)
  );
  // timeout compares the post-increment count, so a limit of N stops with count N
  always_comb begin
    go       = start && (state_q == S_IDLE || state_q == S_DONE);
    seen_all = seen_q | core_done;
    complete = (DONE_MODE != 0) ? |seen_all : &seen_all;
    timeout  = (limit_q != '0) && (cnt_nxt == limit_q);
    state_d  = state_q;
    tmr_d    = tmr_q;
    limit_d  = limit_q;
    seen_d   = seen_q;
    status_d = status_q;
    case (state_q)
      S_IDLE, S_DONE: if (go) begin
        state_d  = S_RESET_HOLD;
        tmr_d    = RST_LOAD;
        limit_d  = run_limit;
        seen_d   = '0;
        status_d = ST_NONE;
      end
      S_RESET_HOLD: begin
        state_d = (tmr_q == '0) ? S_RUN : S_RESET_HOLD;
        tmr_d   = tmr_q - 8'd1;
      end
      S_RUN: begin
        seen_d = seen_all;
        if (complete || timeout) begin
          status_d = complete ? ST_COMPLETE : ST_TIMEOUT;
          state_d  = (DRAIN_CYCLES == 0) ? S_DUMP : S_DRAIN;
          tmr_d    = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        state_d = (tmr_q == '0) ? S_DUMP : S_DRAIN;
        tmr_d   = tmr_q - 8'd1;
      end
      S_DUMP:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      limit_q      <= '0;
      seen_q       <= '0;
      status_q     <= ST_NONE;
      core_reset_q <= 1'b1;
      dump_req_q   <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      limit_q      <= limit_d;
      seen_q       <= seen_d;
      status_q     <= status_d;
      core_reset_q <= state_d == S_IDLE || state_d == S_RESET_HOLD || state_d == S_DONE;
      dump_req_q   <= state_d == S_DUMP;
      finish_q     <= state_d == S_DONE;
    end
  assign core_reset = core_reset_q;
  assign dump_req   = dump_req_q;
  assign finish     = finish_q;
  assign status     = status_q;
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: three configurations of run_controller driven one run at a time;
// expected dumps are queued at start and matched by a monitor on each dump_req.
module tb_run_controller;
  localparam int INF = 1000;
  localparam int RSTC [3] = '{4, 2, 1};
  localparam int DRN  [3] = '{2, 0, 3};
  localparam int WID  [3] = '{32, 8, 4};
  localparam int MODE [3] = '{0, 0, 1};
  localparam int NC   [3] = '{1, 4, 4};
  typedef struct {int g; int at; logic [1:0] st; logic [31:0] cnt;} exp_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        stv [3], crst [3], dmp [3], fin [3], prev [3];
  logic [31:0] lim [3], cnt_w [3];
  logic [3:0]  cd [3];
  logic [1:0]  stat [3];
  logic [31:0] c0;
  logic [7:0]  c1;
  logic [3:0]  c2;
  int checks = 0, errors = 0, cyc = 0;
  int p [4], ln [4];
  exp_t sb [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign cnt_w[0] = c0;
  assign cnt_w[1] = {24'd0, c1};
  assign cnt_w[2] = {28'd0, c2};
  run_controller u0 (
    .clk(clk), .reset(rst), .start(stv[0]), .run_limit(lim[0]), .core_done(cd[0][0]),
    .core_reset(crst[0]), .dump_req(dmp[0]), .finish(fin[0]), .cycle_count(c0), .status(stat[0]));
  run_controller #(.NCORE(4), .CNT_W(8), .RST_CYCLES(2), .DRAIN_CYCLES(0)) u1 (
    .clk(clk), .reset(rst), .start(stv[1]), .run_limit(lim[1][7:0]), .core_done(cd[1]),
    .core_reset(crst[1]), .dump_req(dmp[1]), .finish(fin[1]), .cycle_count(c1), .status(stat[1]));
  run_controller #(.NCORE(4), .CNT_W(4), .RST_CYCLES(1), .DRAIN_CYCLES(3), .DONE_MODE(1)) u2 (
    .clk(clk), .reset(rst), .start(stv[2]), .run_limit(lim[2][3:0]), .core_done(cd[2]),
    .core_reset(crst[2]), .dump_req(dmp[2]), .finish(fin[2]), .cycle_count(c2), .status(stat[2]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // stop cycle from the pulse schedule: last first-pulse (all) or earliest (any), vs limit
  function automatic int stop_k(input int g, input int limit, output int st);
    int comp, tmo;
    comp = (MODE[g] != 0) ? INF : 0;
    for (int c = 0; c < NC[g]; c++)
      if (MODE[g] != 0) begin
        if (p[c] != 0 && p[c] < comp) comp = p[c];
      end else if (p[c] == 0) comp = INF;
      else if (p[c] > comp) comp = p[c];
    tmo = (limit == 0) ? INF : limit;
    st = (comp <= tmo) ? 1 : 2;
    return (comp < tmo) ? comp : tmo;
  endfunction
  function automatic int satc(input int g, input int k);
    return (WID[g] < 32 && k > (1 << WID[g]) - 1) ? (1 << WID[g]) - 1 : k;
  endfunction
  task automatic setp(input int a, input int b, input int c, input int d);
    p = '{a, b, c, d};
    ln = '{1, 1, 1, 1};
  endtask
  task automatic run(input int g, input int limit, input bit rd);
    int k, st, xc, e0, es, ed, kn;
    k = stop_k(g, limit, st);
    xc = satc(g, k);
    @(negedge clk);
    lim[g] = limit;
    stv[g] = 1'b1;
    @(negedge clk);
    e0 = cyc;
    stv[g] = 1'b0;
    lim[g] = $urandom;
    chk("finish_drop", fin[g], 0);
    chk("count_clear", cnt_w[g], 0);
    chk("status_clear", stat[g], 0);
    es = e0 + RSTC[g] + k;
    ed = es + DRN[g];
    sb.push_back('{g, ed, 2'(st), xc});
    while (cyc <= ed) begin
      if (rd && cyc == es) begin
        rst = 1'b1;
        #1;
        chk("rst_core_reset", crst[g], 1);
        chk("rst_dump", dmp[g], 0);
        chk("rst_finish", fin[g], 0);
        chk("rst_count", cnt_w[g], 0);
        chk("rst_status", stat[g], 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        cd[g] = '0;
        repeat (3) begin
          @(negedge clk);
          chk("idle_core_reset", crst[g], 1);
          chk("idle_finish", fin[g], 0);
        end
        return;
      end
      kn = cyc - (e0 + RSTC[g]) + 1;
      for (int c = 0; c < 4; c++)
        cd[g][c] = (kn >= 1 && kn <= k) ? (p[c] != 0 && kn >= p[c] && kn < p[c] + ln[c])
                                         : 1'($urandom_range(0, 1));
      stv[g] = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (cyc < e0 + RSTC[g]) chk("hold_core_reset", crst[g], 1);
      else if (cyc == e0 + RSTC[g]) chk("release_core_reset", crst[g], 0);
    end
    stv[g] = 1'b0;
    chk("dump_missing", sb.size(), 0);
    sb.delete();
    chk("done_finish", fin[g], 1);
    chk("done_core_reset", crst[g], 1);
    chk("done_dump_low", dmp[g], 0);
    repeat ($urandom_range(1, 3)) begin
      cd[g] = 4'($urandom);
      @(negedge clk);
    end
    chk("hold_count", cnt_w[g], xc);
    chk("hold_status", stat[g], st);
    chk("hold_finish", fin[g], 1);
  endtask
  always @(negedge clk)
    for (int g = 0; g < 3; g++) begin
      if (dmp[g]) begin
        chk("dump_single", prev[g], 0);
        if (sb.size() == 0) chk("dump_unexpected", dmp[g], 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("dump_inst", g, e.g);
          chk("dump_cycle", cyc, e.at);
          chk("status", stat[g], e.st);
          chk("cycle_count", cnt_w[g], e.cnt);
          chk("finish_at_dump", fin[g], 0);
        end
      end
      prev[g] <= dmp[g];
    end
  initial begin
    int lmt, st, g;
    for (int i = 0; i < 3; i++) begin
      stv[i] = 1'b0;
      lim[i] = '0;
      cd[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_core_reset", crst[i], 1);
      chk("reset_dump", dmp[i], 0);
      chk("reset_finish", fin[i], 0);
      chk("reset_count", cnt_w[i], 0);
      chk("reset_status", stat[i], 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", crst[0], 1);
    setp(10, 0, 0, 0); run(0, 0, 0);
    setp(0, 0, 0, 0);  run(0, 20, 0);
    setp(8, 0, 0, 0);  run(0, 8, 0);
    setp(15, 0, 0, 0); run(0, 0, 1);
    setp(5, 0, 0, 0);  run(0, 0, 0);
    setp(3, 7, 5, 12); run(1, 0, 0);
    setp(3, 7, 5, 12); run(2, 0, 0);
    setp(25, 25, 25, 25); run(2, 0, 0);
    setp(2, 2, 2, 2);  run(2, 0, 0);
    for (int r = 0; r < 36; r++) begin
      g = r % 3;
      lmt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
      if (WID[g] < 32) lmt = lmt & ((1 << WID[g]) - 1);
      for (int c = 0; c < 4; c++) begin
        p[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
        ln[c] = $urandom_range(1, 3);
      end
      if (stop_k(g, lmt, st) >= INF)
        for (int c = 0; c < 4; c++) if (p[c] == 0) p[c] = $urandom_range(1, 30);
      run(g, lmt, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end
endmodule
